// File: rtl/alu_pkg.sv
// Shared opcode constants, arbiter state encoding and opcode legality helper
// for the two-port ALU arbiter.
`timescale 1ns/1ps
package alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   function automatic logic op_is_legal(input logic [2:0] op);
      return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
             (op == OP_SUB) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU: AND, OR, ADD, SUB, unsigned SLT; any other
// opcode yields z=0. ex flags signed overflow on ADD/SUB only.
`timescale 1ns/1ps
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] z,
   output logic             ex
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      z  = '0;
      ex = 1'b0;
      case (op)
         OP_AND: z = a & b;
         OP_OR:  z = a | b;
         OP_ADD: begin
            z  = sum;
            ex = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            z  = diff;
            ex = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: z[0] = (a < b);
         default: z = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of one shared alu_core.
// Define ALU_ARB_OPCHECK_EN to report illegal opcodes on resp_err.
`timescale 1ns/1ps
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int FIRST_PRI = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic [2:0]       req_op0,
   input  logic [2:0]       req_op1,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_z,
   output logic             resp_zero,
   output logic             resp_ex,
   output logic             resp_err,
   output arb_state_t       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // req_ready is a combinational one-hot grant, only ever raised in IDLE.
   localparam logic PRI_RST = (FIRST_PRI != 0);

   arb_state_t       state_q, state_d;
   logic             pri_q, pri_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic             id_q, id_d;
   logic             resp_id_q, resp_id_d;
   logic [WIDTH-1:0] resp_z_q, resp_z_d;
   logic             resp_zero_q, resp_zero_d;
   logic             resp_ex_q, resp_ex_d;
   logic             resp_err_q, resp_err_d;

   logic             grant_id;
   logic [WIDTH-1:0] alu_z;
   logic             alu_ex;

   alu_core #(.WIDTH(WIDTH)) u_alu (
      .a  (a_q),
      .b  (b_q),
      .op (op_q),
      .z  (alu_z),
      .ex (alu_ex)
   );

   // Lone requester wins outright; contention goes to the priority holder.
   assign grant_id = (req_valid == 2'b10) ? 1'b1 :
                     (req_valid == 2'b11) ? pri_q : 1'b0;

   always_comb begin
      state_d     = state_q;
      pri_d       = pri_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      id_d        = id_q;
      resp_id_d   = resp_id_q;
      resp_z_d    = resp_z_q;
      resp_zero_d = resp_zero_q;
      resp_ex_d   = resp_ex_q;
      resp_err_d  = resp_err_q;
      req_ready   = 2'b00;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready = grant_id ? 2'b10 : 2'b01;
               a_d       = grant_id ? req_a1  : req_a0;
               b_d       = grant_id ? req_b1  : req_b0;
               op_d      = grant_id ? req_op1 : req_op0;
               id_d      = grant_id;
               pri_d     = ~grant_id;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            resp_id_d   = id_q;
            resp_z_d    = alu_z;
            resp_zero_d = (alu_z == '0);
            resp_ex_d   = alu_ex;
`ifdef ALU_ARB_OPCHECK_EN
            resp_err_d  = ~op_is_legal(op_q);
`else
            resp_err_d  = 1'b0;
`endif
            state_d     = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         pri_q       <= PRI_RST;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         id_q        <= 1'b0;
         resp_id_q   <= 1'b0;
         resp_z_q    <= '0;
         resp_zero_q <= 1'b0;
         resp_ex_q   <= 1'b0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pri_q       <= pri_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         id_q        <= id_d;
         resp_id_q   <= resp_id_d;
         resp_z_q    <= resp_z_d;
         resp_zero_q <= resp_zero_d;
         resp_ex_q   <= resp_ex_d;
         resp_err_q  <= resp_err_d;
      end
   end

   assign resp_valid = (state_q == RESP);
   assign resp_id    = resp_id_q;
   assign resp_z     = resp_z_q;
   assign resp_zero  = resp_zero_q;
   assign resp_ex    = resp_ex_q;
   assign resp_err   = resp_err_q;
   assign dbg_state  = state_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer in front of the team's single 32-bit ALU. It accepts operation requests from two independent requesters over valid/ready handshakes and grants them round-robin. It drives the shared ALU for one execute cycle per granted request, then holds a registered result on a common response port until the consumer accepts it. It sits between the datapath control units and the ALU instance, so the ALU is never driven by two sources at once.

## Interface
- Parameters:
- `WIDTH`, 32, operand and result width.
- `FIRST_PRI`, 0, requester that holds priority after reset (0 or 1).
- Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req_valid[1:0]`  input  2  request valid, one bit per requester.
- `req_ready[1:0]`  output  2  request accepted this cycle (a one-hot grant).
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  input  WIDTH  operands per requester.
- `req_op0`, `req_op1`  input  3  opcode per requester.
- `resp_valid`  output  1  result available.
- `resp_ready`  input  1  consumer accepts the result.
- `resp_id`  output  1  requester that owns the result.
- `resp_z`  output  WIDTH  ALU result.
- `resp_zero`  output  1  result equals 0.
- `resp_ex`  output  1  signed overflow on add or subtract.
- `resp_err`  output  1  illegal opcode; meaningful only with the macro, see Configuration.

## Operation
- Opcodes:
- 000 AND.
- 001 OR.
- 010 ADD.
- 110 SUB.
- 111 SLT: unsigned a<b gives 1, otherwise 0.
- Any other code produces z=0.
- All arithmetic is modulo 2^WIDTH.
- `resp_ex` = signed overflow for ADD and SUB; 0 for every other op.
- State machine states: IDLE, EXEC, RESP.
- IDLE:
- If any `req_valid` is high, grant one requester.
- With one requester valid, grant it; with both valid, grant the one holding priority.
- Assert `req_ready` for the granted bit in that same cycle (combinational from `req_valid` and the priority register).
- Latch a, b, op and id, then go to EXEC.
- EXEC:
- Drive the latched operands into the ALU.
- Register z, zero, ex and err into the response registers.
- Go to RESP.
- RESP:
- Hold `resp_valid`=1 with all response fields stable.
- When `resp_ready` is sampled high, go to IDLE.
- Priority flips to the non-granted requester on every grant, whether or not the other requester was requesting.
- `req_ready` is 0 in EXEC and RESP. A requester keeps `req_valid` and its operands stable until it sees `req_ready`.
- A requester may drop `req_valid` without ever being granted; this has no effect.
- Reset values:
- State IDLE, priority `FIRST_PRI`.
- `req_ready`=0, `resp_valid`=0.
- `resp_id`, `resp_z`, `resp_zero`, `resp_ex`, `resp_err` all 0.
- Reset mid-operation discards the in-flight request and its result; no response is produced for it.

## Timing
- Accept in cycle N (`req_valid`&`req_ready`). ALU evaluates in N+1. `resp_valid` rises in N+2.
- `resp_ready` high in cycle M (M ≥ N+2) returns the state to IDLE in M+1, so the next grant is possible at M+1.
- Peak throughput: one operation per 3 cycles.
- `resp_ready` held high permanently gives exactly 3 cycles per transaction.
- Response fields change only on the EXEC→RESP transition.

## Configuration
- `ALU_ARB_OPCHECK_EN` defined:
- Opcodes outside {000,001,010,110,111} set `resp_err`=1 with `resp_z`=0, `resp_zero`=1, `resp_ex`=0.
- The request still completes the normal handshake.
- Not defined:
- `resp_err` is tied to 0.
- Illegal opcodes return z=0 and zero=1 silently.

## Structure
- Shared package `alu_pkg`:
- Opcode constants `OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`, `OP_SLT`.
- FSM state enum `arb_state_t` (IDLE, EXEC, RESP).
- `alu_arbiter` instantiates one sub-module `alu_core`. This is the combinational WIDTH-bit ALU with outputs z and ex. The arbiter is its only driver.

## Test plan
- Single request: port0 valid with a=5, b=3, op=010; `resp_ready`=1 → `req_ready[0]` at N; `resp_valid` at N+2 with z=8, id=0, zero=0, ex=0.
- Contention: both valid from reset, `FIRST_PRI`=0, port0 op=000 a=b=0xF0F0F0F0, port1 op=110 a=b=7 → port0 granted first (z=0xF0F0F0F0); port1 granted 3 cycles later (z=0, zero=1, id=1).
- Backpressure: `resp_ready`=0 for 5 cycles after `resp_valid` → fields stable, `req_ready`=0 throughout; the transaction completes the cycle `resp_ready` rises.
- Overflow and SLT:
- ADD 0x7FFFFFFF+1 → z=0x80000000, ex=1.
- SLT a=1, b=0xFFFFFFFF → z=1.
- SLT a=b → z=0, zero=1.
- Reset during EXEC with port1 request in flight → all outputs return to reset values immediately; no response issued; the next request gets the normal 2-cycle latency.
- Illegal op 011: macro defined → `resp_err`=1, z=0; macro undefined → `resp_err`=0, z=0.
